// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, request/grant fetch port, 2-entry prefetch queue,
// branch redirect from the decoder and the architectural NZCV flag register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // decoder
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        br_valid,
  input  logic [23:0] br_imm24,
  // flags
  input  logic        flag_we,
  input  logic [3:0]  flag_in,
  output logic [3:0]  flag
);

  localparam int unsigned Depth = 2;

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        inflight_q, inflight_d;
  logic        kill_q, kill_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [3:0]  flag_q, flag_d;
  logic [31:0] buf_instr_q [Depth];
  logic [31:0] buf_pc_q    [Depth];

  logic        pop;
  logic        redirect;
  logic        grant;
  logic        push;
  logic [2:0]  occupancy;
  logic [31:0] br_offset;
  logic [31:0] br_target;

  assign inst_valid  = (count_q != 2'd0);
  assign instruction = buf_instr_q[head_q];
  assign inst_pc     = buf_pc_q[head_q];
  assign flag        = flag_q;

  assign pop      = inst_valid & inst_ready;
  assign redirect = pop & br_valid;

  // Entries that will occupy the queue after this edge: stored + arriving - leaving.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign imem_req  = ~rst & ~redirect & (occupancy < 3'd2);
  assign imem_addr = pc_q;
  assign grant     = imem_req & imem_gnt;

  // A word returning in the redirect cycle belongs to the wrong path and is dropped.
  assign push = imem_rvalid & inflight_q & ~kill_q & ~redirect;

  assign br_offset = {{6{br_imm24[23]}}, br_imm24, 2'b00};
  assign br_target = inst_pc + 32'd8 + br_offset;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q;
    kill_d     = kill_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    flag_d     = flag_q;

    if (imem_rvalid && inflight_q) begin
      inflight_d = 1'b0;
      kill_d     = 1'b0;
    end

    if (grant) begin
      pc_d       = pc_q + 32'd4;
      req_pc_d   = pc_q;
      inflight_d = 1'b1;
    end

    if (redirect) begin
      pc_d    = br_target;
      count_d = 2'd0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
      // Anything still outstanding after this edge is from the old path.
      kill_d  = inflight_d;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      head_d  = head_q ^ pop;
      tail_d  = tail_q ^ push;
    end

    if (flag_we) begin
      flag_d = flag_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'd0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      flag_q     <= 4'd0;
      for (int unsigned i = 0; i < Depth; i++) begin
        buf_instr_q[i] <= 32'd0;
        buf_pc_q[i]    <= 32'd0;
      end
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      flag_q     <= flag_d;
      if (push) begin
        buf_instr_q[tail_q] <= imem_rdata;
        buf_pc_q[tail_q]    <= req_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder with fixed one-cycle latency and a scoreboard of
// expected presented {pc, word} values checked on every decoder pop.
module tb_fetch_unit;

  localparam logic [31:0] WrapReset = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gnt = 1'b1;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        ready = 1'b0;
  logic        br_valid = 1'b0;
  logic [23:0] br_imm = 24'd0;
  logic        flag_we = 1'b0;
  logic [3:0]  flag_in = 4'd0;
  logic        inject = 1'b0;

  logic        req;
  logic [31:0] addr;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic        ivalid;
  logic [3:0]  flag;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = 32'd0;
  logic [31:0] w_instr;
  logic [31:0] w_ipc;
  logic        w_ivalid;
  logic [3:0]  w_flag;

  int          n_checks;
  int          n_fail;
  bit          sb_en;
  logic [31:0] sb_q[$];
  logic [31:0] sb_exp;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (req),
    .imem_addr  (addr),
    .imem_gnt   (gnt),
    .imem_rvalid(rvalid),
    .imem_rdata (rdata),
    .instruction(instr),
    .inst_pc    (ipc),
    .inst_valid (ivalid),
    .inst_ready (ready),
    .br_valid   (br_valid),
    .br_imm24   (br_imm),
    .flag_we    (flag_we),
    .flag_in    (flag_in),
    .flag       (flag)
  );

  fetch_unit #(.RESET_PC(WrapReset)) dut_w (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (w_req),
    .imem_addr  (w_addr),
    .imem_gnt   (1'b1),
    .imem_rvalid(w_rvalid),
    .imem_rdata (w_rdata),
    .instruction(w_instr),
    .inst_pc    (w_ipc),
    .inst_valid (w_ivalid),
    .inst_ready (1'b1),
    .br_valid   (1'b0),
    .br_imm24   (24'd0),
    .flag_we    (1'b0),
    .flag_in    (4'd0),
    .flag       (w_flag)
  );

  // Memory returns its own address as data; inject forces a stray response.
  always @(posedge clk) begin
    rvalid   <= (req && gnt) || inject;
    rdata    <= inject ? 32'hDEAD_BEEF : addr;
    w_rvalid <= w_req;
    w_rdata  <= w_addr;
  end

  always @(negedge clk) begin
    if (sb_en && ivalid && ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: popped pc=%h instr=%h, no entry expected", ipc, instr);
      end else begin
        sb_exp = sb_q.pop_front();
        if (ipc !== sb_exp || instr !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_pop: pc=%h instr=%h, expected pc=%h instr=%h", ipc, instr, sb_exp,
                   sb_exp);
        end
      end
    end
    if (sb_en) begin
      n_checks++;
      if (dut.count_q == 2'd2 && dut.inflight_q && rvalid && !dut.kill_q && !(ivalid && ready))
      begin
        n_fail++;
        $display("FAIL full_push: push into full queue, count=%0d", dut.count_q);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in cycle 0: the first cycle with rst low.
  task automatic do_reset();
    tick();
    rst = 1'b1;
    ready = 1'b0;
    br_valid = 1'b0;
    gnt = 1'b1;
    inject = 1'b0;
    flag_we = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    tick();
    @(negedge clk);
    n_checks++;
    if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", req); end
    n_checks++;
    if (addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", addr); end
    n_checks++;
    if (ivalid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ivalid); end
    n_checks++;
    if (instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_checks++;
    if (ipc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", ipc); end
    n_checks++;
    if (flag !== 4'd0) begin n_fail++; $display("FAIL reset_flag: got %b want 0", flag); end
    n_checks++;
    if (w_addr !== WrapReset) begin
      n_fail++; $display("FAIL reset_wrap_addr: got %h want %h", w_addr, WrapReset);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req !== 1'b1 || addr !== 32'd0) begin
      n_fail++; $display("FAIL first_req: got req=%b addr=%h want 1/0", req, addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 12; i++) sb_q.push_back(32'(4 * i));
    ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      n_checks++;
      if (req !== 1'b1) begin n_fail++; $display("FAIL stream_req c%0d: got %b want 1", c, req); end
      n_checks++;
      if (ivalid !== (c >= 2)) begin
        n_fail++; $display("FAIL stream_valid c%0d: got %b want %b", c, ivalid, c >= 2);
      end
      tick();
    end
    ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL stream_left: %0d entries not presented, want 0", sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 8; i++) sb_q.push_back(32'(4 * i));
    for (int c = 0; c < 15; c++) begin
      ready = (c < 4 || c >= 9);
      @(negedge clk);
      if (c >= 4 && c <= 8) begin
        n_checks++;
        if (req !== 1'b0) begin n_fail++; $display("FAIL bp_req c%0d: got %b want 0", c, req); end
      end
      if (c >= 5 && c <= 8) begin
        n_checks++;
        if (dut.count_q !== 2'd2) begin
          n_fail++; $display("FAIL bp_count c%0d: got %0d want 2", c, dut.count_q);
        end
        n_checks++;
        if (ipc !== 32'h8) begin n_fail++; $display("FAIL bp_head c%0d: got %h want 8", c, ipc); end
      end
      if (c == 9) begin
        n_checks++;
        if (req !== 1'b1) begin n_fail++; $display("FAIL bp_rerise: got %b want 1", req); end
      end
      tick();
    end
    ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL bp_left: %0d entries not presented, want 0", sb_q.size());
    end
  endtask

  task automatic test_grant_stall();
    do_reset();
    for (int i = 0; i < 7; i++) sb_q.push_back(32'(4 * i));
    for (int c = 0; c < 12; c++) begin
      ready = 1'b1;
      gnt = !(c >= 4 && c <= 6);
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        n_checks++;
        if (req !== 1'b1 || addr !== 32'h10) begin
          n_fail++; $display("FAIL stall_addr c%0d: got req=%b addr=%h want 1/10", c, req, addr);
        end
      end
      if (c == 6 || c == 8) begin
        n_checks++;
        if (ivalid !== 1'b0) begin
          n_fail++; $display("FAIL stall_valid c%0d: got %b want 0", c, ivalid);
        end
      end
      tick();
    end
    ready = 1'b0;
    gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL stall_left: %0d entries not presented, want 0", sb_q.size());
    end
  endtask

  task automatic test_branch_fwd();
    do_reset();
    for (int i = 0; i < 5; i++) sb_q.push_back(32'(4 * i));
    for (int i = 0; i < 3; i++) sb_q.push_back(32'h20 + 32'(4 * i));
    br_imm = 24'h000002;
    for (int c = 0; c < 12; c++) begin
      ready = 1'b1;
      br_valid = (c == 6);
      @(negedge clk);
      if (c == 6) begin
        n_checks++;
        if (req !== 1'b0) begin n_fail++; $display("FAIL brf_req: got %b want 0", req); end
      end
      if (c == 7) begin
        n_checks++;
        if (ivalid !== 1'b0 || req !== 1'b1 || addr !== 32'h20) begin
          n_fail++;
          $display("FAIL brf_target: got valid=%b req=%b addr=%h want 0/1/20", ivalid, req, addr);
        end
      end
      if (c == 8) begin
        n_checks++;
        if (ivalid !== 1'b0) begin n_fail++; $display("FAIL brf_gap: got %b want 0", ivalid); end
      end
      tick();
    end
    ready = 1'b0;
    br_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL brf_left: %0d entries not presented, want 0", sb_q.size());
    end
  endtask

  task automatic test_branch_back();
    do_reset();
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h100);
    sb_q.push_back(32'h100);
    sb_q.push_back(32'h104);
    sb_q.push_back(32'h108);
    for (int c = 0; c < 11; c++) begin
      ready = 1'b1;
      br_valid = (c == 2 || c == 5);
      br_imm = (c == 2) ? 24'h00003E : 24'hFFFFFE;
      @(negedge clk);
      if (c == 3 || c == 6) begin
        n_checks++;
        if (ivalid !== 1'b0 || addr !== 32'h100) begin
          n_fail++; $display("FAIL brb_target c%0d: got valid=%b addr=%h want 0/100", c, ivalid,
                             addr);
        end
      end
      tick();
    end
    ready = 1'b0;
    br_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL brb_left: %0d entries not presented, want 0", sb_q.size());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wexp;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      wexp = WrapReset + 32'(4 * c);
      n_checks++;
      if (w_req !== 1'b1 || w_addr !== wexp) begin
        n_fail++; $display("FAIL wrap_addr c%0d: got req=%b addr=%h want 1/%h", c, w_req, w_addr,
                           wexp);
      end
      if (c >= 2) begin
        wexp = WrapReset + 32'(4 * (c - 2));
        n_checks++;
        if (w_ivalid !== 1'b1 || w_ipc !== wexp || w_instr !== wexp) begin
          n_fail++;
          $display("FAIL wrap_pc c%0d: got valid=%b pc=%h instr=%h want 1/%h", c, w_ivalid, w_ipc,
                   w_instr, wexp);
        end
      end
      tick();
    end
  endtask

  task automatic test_flags();
    do_reset();
    flag_we = 1'b1;
    flag_in = 4'b1010;
    @(negedge clk);
    n_checks++;
    if (flag !== 4'b0000) begin n_fail++; $display("FAIL flag_early: got %b want 0000", flag); end
    tick();
    flag_we = 1'b0;
    flag_in = 4'b0101;
    @(negedge clk);
    n_checks++;
    if (flag !== 4'b1010) begin n_fail++; $display("FAIL flag_write: got %b want 1010", flag); end
    tick();
    flag_we = 1'b1;
    @(negedge clk);
    n_checks++;
    if (flag !== 4'b1010) begin n_fail++; $display("FAIL flag_hold: got %b want 1010", flag); end
    tick();
    flag_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (flag !== 4'b0101) begin n_fail++; $display("FAIL flag_write2: got %b want 0101", flag); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) sb_q.push_back(32'(4 * i));
    end
    for (int c = 0; c < 11; c++) begin
      ready = (c != 5);
      rst = (c == 5);
      inject = (c == 5);
      flag_we = (c == 1);
      flag_in = 4'b1010;
      @(negedge clk);
      if (c == 3) begin
        n_checks++;
        if (flag !== 4'b1010) begin n_fail++; $display("FAIL mid_flag_set: got %b want 1010", flag);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (req !== 1'b0) begin n_fail++; $display("FAIL mid_req: got %b want 0", req); end
      end
      if (c == 6) begin
        n_checks++;
        if (ivalid !== 1'b0 || instr !== 32'd0 || ipc !== 32'd0 || flag !== 4'd0) begin
          n_fail++;
          $display("FAIL mid_reset_vals: got valid=%b instr=%h pc=%h flag=%b want 0/0/0/0",
                   ivalid, instr, ipc, flag);
        end
        n_checks++;
        if (req !== 1'b1 || addr !== 32'd0) begin
          n_fail++; $display("FAIL mid_refetch: got req=%b addr=%h want 1/0", req, addr);
        end
      end
      if (c == 7) begin
        n_checks++;
        if (ivalid !== 1'b0) begin n_fail++; $display("FAIL mid_stray: got valid=%b want 0", ivalid);
        end
      end
      tick();
    end
    ready = 1'b0;
    inject = 1'b0;
    flag_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL mid_left: %0d entries not presented, want 0", sb_q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    sb_en = 1'b0;
    test_reset();
    sb_en = 1'b1;
    test_stream();
    test_backpressure();
    test_grant_stall();
    test_branch_fwd();
    test_branch_back();
    test_wrap();
    test_flags();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage. Sits directly upstream of the instruction decoder. It keeps the program counter and issues requests to instruction memory through a request/grant interface with a fixed one-cycle response. Returned words are buffered in a 2-entry prefetch queue and presented to the decoder with a valid/ready handshake. It also takes branch redirects back from the decoder and holds the architectural NZCV flag register that feeds the decoder's `flag` input.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address (word-aligned).
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; high exactly one cycle after each grant.
- `imem_rdata`  in  32  instruction word.
- `instruction`  out  32  queue-head instruction to the decoder.
- `inst_pc`  out  32  address of `instruction`.
- `inst_valid`  out  1  queue head valid.
- `inst_ready`  in  1  decoder accepts the head.
- `br_valid`  in  1  the accepted instruction is a taken branch (decoder `jmpEnable`).
- `br_imm24`  in  24  branch offset field (decoder `immadiateInst[23:0]`).
- `flag_we`  in  1  update flags (from execute).
- `flag_in`  in  4  new NZCV.
- `flag`  out  4  registered NZCV to the decoder.

## Operation
- State:
  - `pc`: next fetch address.
  - Queue: 2 entries of {instr, pc}, with head/tail pointers and `count`.
  - `inflight`: a granted request awaits its response.
  - `kill`: the in-flight response must be dropped.
- Definitions:
  - `pop` = `inst_valid & inst_ready`.
  - `grant` = `imem_req & imem_gnt`.
  - `redirect` = `pop & br_valid`.
- Request rule:
  - `imem_req` = `!rst & !redirect & (count + inflight - pop < 2)`.
  - `imem_addr` = `pc`.
  - While `imem_req & !imem_gnt`, `imem_addr` holds stable.
- On grant:
  - `pc` <= `pc + 4`, modulo 2^32, wrapping 0xFFFF_FFFC to 0.
  - `inflight` <= 1, and the entry pc is recorded as the granted address.
- On `imem_rvalid`:
  - If `kill` is 0, push {`imem_rdata`, recorded pc}.
  - If `kill` is 1, discard the word and clear `kill`.
  - Pushing into a full queue cannot occur by construction; the bench asserts it never happens.
- Outputs:
  - `instruction`/`inst_pc` come from queue-head storage and are registered, with no combinational path from `imem_rdata`.
  - `inst_valid` = `count != 0`.
- Redirect (evaluated only when `pop`; `br_valid` without `pop` is ignored):
  - Target = `inst_pc + 8 + (sign_extend(br_imm24) << 2)`, modulo 2^32.
  - `pc` <= target.
  - The queue is flushed (`count` <= 0).
  - `kill` <= 1 if a response is outstanding after this edge. That covers a grant from the previous cycle whose response has not yet arrived; a response arriving in the redirect cycle itself is simply not pushed.
  - `imem_req` is low in the redirect cycle.
- Flags: `flag` <= `flag_in` when `flag_we`; otherwise held. Flags are independent of redirect and flush.

## Timing
- Reset values:
  - `pc` = `imem_addr` = `RESET_PC`.
  - `imem_req` = 0.
  - `count` = 0, `inst_valid` = 0.
  - `instruction` = 0, `inst_pc` = 0.
  - `inflight` = 0, `kill` = 0.
  - `flag` = 0.
- Reset mid-operation: the queue, in-flight and kill state are cleared on that edge. A response arriving in the cycle after reset is ignored (`inflight` = 0).
- Latency: if a request is granted in cycle N, the word arrives as `imem_rvalid` in N+1, and `inst_valid` with that word is high in N+2.
- First fetch: `imem_req` rises in the first cycle with `rst` low.
- Throughput: with `imem_gnt` and `inst_ready` tied high, one instruction per cycle in steady state.
- Backpressure: with `inst_ready` low, the queue fills to 2 and `imem_req` drops. It re-rises in the cycle `pop` is high.
- Redirect: `inst_valid` is low in the cycle after the redirect edge. The first target-path request is issued that same cycle, and the first target instruction is valid 2 cycles after that grant.
- Simultaneous `rvalid` with `pop`, queue at count 2: push and pop in the same edge; count stays 2.

## Test plan
- Reset and stream, `RESET_PC`=0, `imem_gnt`=1, `inst_ready`=1, `imem_rdata`=addr:
  - `inst_valid` rises 2 cycles after the first request.
  - `inst_pc` runs 0, 4, 8, ... one per cycle, and `instruction` equals `inst_pc`.
- Backpressure: `inst_ready`=0 for 5 cycles → `count` reaches 2, `imem_req`=0, and the head stays at the same pc. Release → the words appear in order with no loss or duplication.
- Grant stall: `imem_gnt`=0 for 3 cycles while `imem_req`=1 → `imem_addr` stable at 0x10. On grant, the response at 0x10 is delivered.
- Branch forward: branch at `inst_pc`=0x10 with `br_imm24`=0x000002 → the next valid `inst_pc` is 0x20, and the in-flight word from 0x14 is never presented.
- Branch backward and wrap:
  - `inst_pc`=0x100 with `br_imm24`=0xFFFFFE → target 0x100.
  - `RESET_PC`=0xFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0.
- Flags and reset: `flag_we`=1 with `flag_in`=4'b1010 → `flag`=4'b1010 next cycle. `rst` asserted mid-stream → all outputs return to their reset values on that edge, and the response arriving in the following cycle is not presented.
